// File: rtl/frame_capture_ctrl_if.sv
// Frame-RAM write port and FFT consumer handshake for frame_capture_ctrl.
// master drives RAM writes and frame hand-off; slave is the RAM/consumer side.
interface frame_capture_ctrl_if #(
    parameter int N = 256
);
    localparam int AW = $clog2(N);

    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_valid;
    logic          frame_bank;
    logic          frame_ready;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data,
        output frame_valid, frame_bank,
        input  frame_ready
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  frame_valid, frame_bank,
        output frame_ready
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Microphone frame capture: sample-rate divider, DC removal, ping-pong frame RAM writer.
// Define MIC_SAT_EN to saturate samples to 12 bits; otherwise they wrap.
module frame_capture_ctrl #(
    parameter int N           = 256,
    parameter int CLK_FREQ    = 10000000,
    parameter int SAMPLE_RATE = 5000,
    parameter int DC_OFFSET   = 1352
) (
    input  logic        clk_10MHz,
    input  logic        rst,
    input  logic        enable,
    input  logic        oneshot,
    input  logic [11:0] adc_sample,
    input  logic        clear_overrun,
    frame_capture_ctrl_if.master fc,
    output logic        sample_strobe,
    output logic        overrun,
    output logic        busy
);
    localparam int DIV = CLK_FREQ / SAMPLE_RATE;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic          wr_en_q, wr_bank_q;
    logic [AW-1:0] addr_q;
    logic [11:0]   data_q;
    logic          valid_q, bank_q;
    logic          overrun_q, shot_q;
    logic [11:0]   sample;
    logic          capture, complete, accept, drop;

    assign sample_strobe = (div_q == DW'(DIV - 1));

`ifdef MIC_SAT_EN
    logic signed [12:0] diff;
    always_comb begin
        diff = $signed({1'b0, adc_sample}) - $signed(13'(DC_OFFSET));
        if (diff > 13'sd2047)
            sample = 12'h7FF;
        else if (diff < -13'sd2048)
            sample = 12'h800;
        else
            sample = diff[11:0];
    end
`else
    assign sample = adc_sample - 12'(DC_OFFSET);
`endif

    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // The write of address N-1 finishes the frame; a release in the
    // same cycle frees the slot so the new frame is taken, not dropped.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        complete = wr_en_q && (addr_q == AW'(N - 1));
        accept   = complete && (!valid_q || fc.frame_ready);
        drop     = complete && valid_q && !fc.frame_ready;
        unique case (state_q)
            IDLE: if (enable) state_d = FILL;
            FILL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    capture = sample_strobe;
                    if (accept && shot_q) state_d = DONE;
                end
            end
            DONE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            bank_q    <= 1'b0;
            overrun_q <= 1'b0;
            shot_q    <= 1'b0;
        end else begin
            div_q   <= sample_strobe ? '0 : div_q + DW'(1);
            wr_en_q <= capture;
            if (capture) data_q <= sample;
            if (state_q == IDLE && enable) shot_q <= oneshot;

            if (state_q != FILL || !enable || complete)
                addr_q <= '0;
            else if (wr_en_q)
                addr_q <= addr_q + AW'(1);

            if (valid_q && fc.frame_ready) valid_q <= 1'b0;
            if (accept) begin
                valid_q   <= 1'b1;
                bank_q    <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
            end

            if (drop)
                overrun_q <= 1'b1;
            else if (clear_overrun)
                overrun_q <= 1'b0;
        end
    end

    assign fc.wr_en       = wr_en_q;
    assign fc.wr_bank     = wr_bank_q;
    assign fc.wr_addr     = addr_q;
    assign fc.wr_data     = data_q;
    assign fc.frame_valid = valid_q;
    assign fc.frame_bank  = bank_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q == FILL);
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with N=8 and a divide-by-4 strobe.
// Expected wr_data for code 4095 follows MIC_SAT_EN.
module tb_frame_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        oneshot = 1'b0;
    logic [11:0] adc_sample = 12'd0;
    logic        clear_overrun = 1'b0;
    logic        sample_strobe, overrun, busy;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc;
    logic [11:0] exp_hi;

    frame_capture_ctrl_if #(.N(8)) fc ();

    frame_capture_ctrl #(
        .N(8), .CLK_FREQ(20), .SAMPLE_RATE(5), .DC_OFFSET(1352)
    ) dut (
        .clk_10MHz(clk),
        .rst(rst),
        .enable(enable),
        .oneshot(oneshot),
        .adc_sample(adc_sample),
        .clear_overrun(clear_overrun),
        .fc(fc),
        .sample_strobe(sample_strobe),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_wr();
        int k = 0;
        @(negedge clk);
        while (!fc.wr_en && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("wr_timeout", 32'(fc.wr_en), 1);
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_wr_en"}, 32'(fc.wr_en), 0);
        check({tag, "_wr_bank"}, 32'(fc.wr_bank), 0);
        check({tag, "_wr_addr"}, 32'(fc.wr_addr), 0);
        check({tag, "_valid"}, 32'(fc.frame_valid), 0);
        check({tag, "_bank"}, 32'(fc.frame_bank), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
`ifdef MIC_SAT_EN
        exp_hi = 12'h7FF;
`else
        exp_hi = 12'hAB7;
`endif
        fc.frame_ready = 1'b0;

        #12;
        check_idle_outs("reset");
        check("reset_wr_data", 32'(fc.wr_data), 0);
        check("reset_strobe", 32'(sample_strobe), 0);

        // frame 1: mid-rail input gives zero samples into bank 0
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        adc_sample = 12'd1352;
        wait_wr();
        check("f1_addr0", 32'(fc.wr_addr), 0);
        check("f1_data0", 32'(fc.wr_data), 0);
        check("f1_bank0", 32'(fc.wr_bank), 0);
        check("f1_busy", 32'(busy), 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!fc.wr_en && cyc < 20);
        check("wr_period", 32'(cyc), 4);
        check("f1_addr1", 32'(fc.wr_addr), 1);
        for (int i = 2; i < 8; i++) begin
            wait_wr();
            check("f1_addr", 32'(fc.wr_addr), 32'(i));
            check("f1_data", 32'(fc.wr_data), 0);
            check("f1_bank", 32'(fc.wr_bank), 0);
        end
        check("f1_valid_late", 32'(fc.frame_valid), 0);
        adc_sample = 12'd4095;
        @(negedge clk);
        check("f1_valid", 32'(fc.frame_valid), 1);
        check("f1_fbank", 32'(fc.frame_bank), 0);
        check("f1_wr_en_one", 32'(fc.wr_en), 0);

        // frame 2 into bank 1, no release -> overrun
        wait_wr();
        check("f2_addr0", 32'(fc.wr_addr), 0);
        check("f2_bank", 32'(fc.wr_bank), 1);
        check("data_4095", 32'(fc.wr_data), 32'(exp_hi));
        adc_sample = 12'd0;
        wait_wr();
        check("f2_addr1", 32'(fc.wr_addr), 1);
        check("data_0", 32'(fc.wr_data), 32'h0AB8);
        adc_sample = 12'd1352;
        for (int i = 2; i < 8; i++) begin
            wait_wr();
            check("f2_addr", 32'(fc.wr_addr), 32'(i));
        end
        check("f2_ovr_before", 32'(overrun), 0);
        @(negedge clk);
        check("f2_overrun", 32'(overrun), 1);
        check("f2_fbank", 32'(fc.frame_bank), 0);
        check("f2_valid", 32'(fc.frame_valid), 1);
        wait_wr();
        check("f3_addr0", 32'(fc.wr_addr), 0);
        check("f3_bank_rewrite", 32'(fc.wr_bank), 1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // frame 3: release coincides with completion
        for (int i = 1; i < 8; i++) begin
            wait_wr();
            check("f3_addr", 32'(fc.wr_addr), 32'(i));
        end
        fc.frame_ready = 1'b1;
        @(negedge clk);
        fc.frame_ready = 1'b0;
        check("sim_valid", 32'(fc.frame_valid), 1);
        check("sim_fbank", 32'(fc.frame_bank), 1);
        check("sim_overrun", 32'(overrun), 0);
        wait_wr();
        check("f4_addr0", 32'(fc.wr_addr), 0);
        check("f4_bank", 32'(fc.wr_bank), 0);
        fc.frame_ready = 1'b1;
        @(negedge clk);
        fc.frame_ready = 1'b0;
        check("release", 32'(fc.frame_valid), 0);

        // oneshot: exactly one frame, then DONE
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_addr", 32'(fc.wr_addr), 0);
        oneshot = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_wr();
            check("os_addr", 32'(fc.wr_addr), 32'(i));
            check("os_bank", 32'(fc.wr_bank), 0);
        end
        oneshot = 1'b0;
        @(negedge clk);
        check("os_valid", 32'(fc.frame_valid), 1);
        check("os_fbank", 32'(fc.frame_bank), 0);
        check("os_busy", 32'(busy), 0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fc.wr_en) cyc++;
        end
        check("os_no_writes", 32'(cyc), 0);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;
        wait_wr();
        check("restart_addr", 32'(fc.wr_addr), 0);
        check("restart_bank", 32'(fc.wr_bank), 1);

        // enable dropped at address 5
        for (int i = 1; i < 6; i++) begin
            wait_wr();
            check("drop_addr", 32'(fc.wr_addr), 32'(i));
        end
        enable = 1'b0;
        @(negedge clk);
        check("drop_addr0", 32'(fc.wr_addr), 0);
        check("drop_busy", 32'(busy), 0);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fc.wr_en) cyc++;
        end
        check("drop_no_writes", 32'(cyc), 0);

        // enable falls in a strobe cycle: no write
        enable = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!sample_strobe && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("strobe_seen", 32'(sample_strobe), 1);
        enable = 1'b0;
        @(negedge clk);
        check("strobe_drop_wr", 32'(fc.wr_en), 0);

        // asynchronous reset mid-frame
        enable = 1'b1;
        wait_wr();
        check("pre_rst_addr0", 32'(fc.wr_addr), 0);
        wait_wr();
        check("pre_rst_addr1", 32'(fc.wr_addr), 1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outs("async_rst");
        check("async_rst_data", 32'(fc.wr_data), 0);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fc.wr_en) cyc++;
        end
        check("rst_no_writes", 32'(cyc), 0);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences microphone capture into fixed-length frames for the spectrum path. Generates the sample-rate strobe from the 10 MHz ADC clock and removes the mid-rail DC offset from each ADC code. Writes samples into a two-bank (ping-pong) frame RAM and hands each completed bank to the FFT consumer through a valid/ready handshake. Flags overruns when the consumer falls behind.

## Interface
- N, 256: samples per frame; power of two, ≥ 4.
- CLK_FREQ, 10000000: clk_10MHz frequency in Hz.
- SAMPLE_RATE, 5000: sample rate in Hz; DIV = CLK_FREQ/SAMPLE_RATE must be an integer ≥ 2.
- DC_OFFSET, 1352: ADC code subtracted from every sample (half of 3V3 VCC).

- clk_10MHz  in  1  sole clock.
- rst  in  1  reset; asynchronous assert, active-low.
- enable  in  1  capture enable; level-sensitive.
- oneshot  in  1  sampled on the IDLE→FILL transition; 1 = capture exactly one frame.
- adc_sample  in  12  unsigned ADC code, CH0.
- frame_ready  in  1  consumer has finished with frame_bank.
- clear_overrun  in  1  synchronous clear of overrun.
- wr_en  out  1  frame-RAM write strobe, one cycle per sample.
- wr_bank  out  1  bank being written.
- wr_addr  out  $clog2(N)  write address.
- wr_data  out  12  signed two's-complement sample.
- frame_valid  out  1  completed frame available in frame_bank.
- frame_bank  out  1  bank holding the completed frame.
- sample_strobe  out  1  one-cycle pulse at SAMPLE_RATE, free-running.
- overrun  out  1  sticky; a completed frame was dropped.
- busy  out  1  high in FILL.

## Operation
- Divider: counter 0..DIV-1, free-running from reset. sample_strobe=1 in the cycle count==DIV-1.
- States:
  - IDLE: enable=1 → FILL. Latch oneshot. wr_addr=0.
  - FILL: enable=0 → IDLE. Partial frame discarded, wr_addr reset to 0, pending frame_valid kept.
  - DONE (oneshot only, after its frame is presented): enable=0 → IDLE.
- In FILL, each strobe captures adc_sample. wr_data = adc_sample − DC_OFFSET, computed 13-bit signed, then reduced to 12 bits per Configuration.
- Frame completion is the write of wr_addr N-1.
  - If no frame is pending: frame_valid←1, frame_bank←wr_bank, wr_bank toggles, wr_addr←0.
  - If frame_valid is still high: overrun←1, the completed frame is dropped, wr_bank is unchanged, wr_addr←0 (bank overwritten).
  - With oneshot latched, go to DONE after presenting the frame; on a drop, stay in FILL.
- Handshake: frame_valid holds until a cycle with frame_ready=1, then clears on the next edge. frame_ready while frame_valid=0 is ignored.
- Completion and frame_ready in the same cycle: the release is processed first. The new frame is accepted, frame_valid stays 1, frame_bank updates, no overrun.
- clear_overrun coincident with a new overrun: the set wins.

## Timing
- Reset values: all outputs 0. wr_bank=0, divider=0, state IDLE.
- Strobe at edge k (FILL): adc_sample is registered at edge k. wr_en/wr_addr/wr_data/wr_bank are valid during cycle k+1, for exactly one cycle.
- wr_addr increments after each write; it wraps N-1→0 only via completion.
- frame_valid rises one cycle after the wr_en cycle for address N-1, so RAM write completion precedes the handoff.
- Minimum frame period N·DIV cycles; the consumer must assert frame_ready within that period to avoid overrun.
- enable falling in the same cycle as a strobe: no write is issued.
- rst low mid-frame: immediate return to reset values; frame RAM contents undefined to the consumer.

## Configuration
- MIC_SAT_EN defined: the 13-bit difference saturates to [−2048, 2047].
  - Example: code 4095 → 2047; code 0 → −1352.
- MIC_SAT_EN undefined: the difference wraps modulo 2^12.
  - Example: code 4095 → 2743−4096 = −1353.

## Test plan
Bench uses N=8, CLK_FREQ=20, SAMPLE_RATE=5 (DIV=4).
- Reset, enable=1, constant adc_sample=1352: wr_en every 4 cycles with addr 0..7 and wr_data=0. frame_valid=1, frame_bank=0 one cycle after the addr-7 write; subsequent writes go to bank 1.
- adc_sample=4095: with MIC_SAT_EN, wr_data=12'h7FF; without it, wr_data=12'hAB7 (−1353). adc_sample=0 → 12'hAB8 (−1352) in both builds.
- Hold frame_ready=0 for two frames: second completion sets overrun=1, frame_bank stays 0, bank 1 is rewritten. clear_overrun → 0.
- frame_ready pulsed in the exact cycle of the next completion: frame_valid stays 1, frame_bank toggles, overrun stays 0.
- oneshot=1, enable=1: one frame written, state DONE, no further wr_en. Drop enable then raise it: capture restarts at addr 0.
- Drop enable at addr 5, then rst low mid-frame: writes stop and wr_addr=0. On rst, all outputs 0 asynchronously.
